mod4051_horner_reducer: RTL

- Sequential reverse-side partner of the per-chunk mod-4051 residue tables.
- Consumes a wide binary operand as a stream of 6-bit chunks, most-significant chunk first.
- Folds each chunk with Horner's rule, acc = (acc*64 + chunk) mod 4051, and returns the 12-bit residue of the whole operand.
- Used to cross-check table-based forward conversion results and to reduce operands whose chunk positions have no tables.

---
 rtl/mod4051_horner_reducer_if.sv | 18 +
 rtl/mod4051_horner_reducer.sv | 81 ++++++++
 2 files changed

// File: rtl/mod4051_horner_reducer_if.sv
// mod4051_horner_reducer_if: chunk-in / residue-out handshake bundle for the Horner reducer
interface mod4051_horner_reducer_if #(
  parameter int CHUNK_W = 6,
  parameter int RES_W   = 12
);
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W-1:0] in_chunk;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [RES_W-1:0]   out_res;
  logic               len_err;
  modport master (output in_valid, in_chunk, in_last, out_ready,
                  input  in_ready, out_valid, out_res, len_err);
  modport slave  (input  in_valid, in_chunk, in_last, out_ready,
                  output in_ready, out_valid, out_res, len_err);
endinterface

// File: rtl/mod4051_horner_reducer.sv
// mod4051_horner_reducer: streams 6-bit chunks MSB-first and folds acc = (acc*64 + chunk) mod 4051
// Optional chunk-count check enabled by defining MOD4051_HORNER_LENCHK_EN.
module mod4051_horner_reducer #(
  parameter int MOD     = 4051,
  parameter int CHUNK_W = 6,
  parameter int RES_W   = 12
`ifdef MOD4051_HORNER_LENCHK_EN
  ,
  parameter int IN_W    = 300,
  parameter int N_CHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W
`endif
) (
  input logic clk,
  input logic rst,
  mod4051_horner_reducer_if.slave io
);
  localparam int RW1 = RES_W + 1;
  localparam int K   = (1 << RES_W) - MOD;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t               state_q, state_d;
  logic [RES_W-1:0]     acc_q, acc_d, out_res_q, out_res_d, res;
  logic [RES_W+CHUNK_W-1:0] t;
  logic [CHUNK_W-1:0]   q;
  logic [RES_W:0]       r1, r2, r3;
  logic                 fire, done;
  // t = q*2^12 + low, so t - q*MOD = low + q*(2^12-MOD); that sum is < 2*MOD
  always_comb begin
    t    = {acc_q, io.in_chunk};
    q    = t[RES_W+CHUNK_W-1:RES_W];
    r1   = {1'b0, t[RES_W-1:0]} + RW1'(q) * RW1'(K);
    r2   = (r1 >= RW1'(MOD)) ? r1 - RW1'(MOD) : r1;
    r3   = (r2 >= RW1'(MOD)) ? r2 - RW1'(MOD) : r2;
    res  = RES_W'(r3);
    fire = io.in_valid && (state_q == ACCUM);
    done = fire && io.in_last;
    acc_d     = fire ? (io.in_last ? '0 : res) : acc_q;
    out_res_d = done ? res : out_res_q;
  end
  always_comb begin
    state_d = (state_q == ACCUM) ? (done ? HOLD : ACCUM) : (io.out_ready ? ACCUM : HOLD);
  end
`ifdef MOD4051_HORNER_LENCHK_EN
  logic [5:0] cnt_q, cnt_d, cnt_inc;
  logic       len_err_q, len_err_d;
  always_comb begin
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 6'd1;
    cnt_d     = fire ? (io.in_last ? '0 : cnt_inc) : cnt_q;
    len_err_d = done ? (32'(cnt_inc) != 32'(N_CHUNK)) : len_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end
`endif
  always_comb begin
    io.in_ready  = (state_q == ACCUM);
    io.out_valid = (state_q == HOLD);
    io.out_res   = out_res_q;
`ifdef MOD4051_HORNER_LENCHK_EN
    io.len_err   = len_err_q;
`else
    io.len_err   = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      out_res_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      out_res_q <= out_res_d;
    end
  end
endmodule
